emulib_ready_valid_skid_buffer: RTL

- Ready/valid register slice placed directly upstream of the fork stage.
- The fork's input ready is the combinational AND of all branch readies. Without a slice, that AND reaches back into the producer as a long combinational path.
- This block cuts the valid/data path, the ready path, or both. In full mode it keeps one-transfer-per-cycle throughput with a 2-entry skid register.
- Its o_* side connects to the fork's i_valid/i_ready. o_data travels alongside to all fork branches.

---
 rtl/emulib_ready_valid_skid_buffer_pkg.sv | 18 +
 rtl/emulib_ready_valid_skid_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/emulib_ready_valid_skid_buffer_pkg.sv
// Shared encodings and helpers for the ready/valid slice and fork/join family.
package emulib_ready_valid_skid_buffer_pkg;

    localparam int unsigned RV_COUNT_W = 2;

    // Occupancy state; the encoding doubles as the entry count.
    typedef enum logic [RV_COUNT_W-1:0] {
        RV_EMPTY = 2'd0,
        RV_ONE   = 2'd1,
        RV_FULL  = 2'd2
    } rv_state_e;

    // A transfer happens when valid and ready are both high.
    function automatic logic rv_fire(input logic v, input logic r);
        return v & r;
    endfunction

endpackage

// File: rtl/emulib_ready_valid_skid_buffer.sv
// Ready/valid register slice upstream of the fork: cuts the forward path,
// the backward (ready) path, or both, selected by parameters.
module emulib_ready_valid_skid_buffer
    import emulib_ready_valid_skid_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter bit          FORWARD_REG  = 1'b1,
    parameter bit          BACKWARD_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [RV_COUNT_W-1:0] count
);

    if (FORWARD_REG && BACKWARD_REG) begin : g_full
        rv_state_e             r_state;
        rv_state_e             w_state_next;
        logic                  r_ready_q;
        logic [DATA_WIDTH-1:0] r_main_data;
        logic [DATA_WIDTH-1:0] r_skid_data;
        logic                  w_i_fire;
        logic                  w_o_fire;
        logic                  w_load_main_in;
        logic                  w_load_main_skid;
        logic                  w_load_skid;

        assign w_i_fire = rv_fire(i_valid, r_ready_q);
        assign w_o_fire = rv_fire(o_valid, o_ready);

        // Next occupancy state and which register loads this cycle.
        always_comb begin
            w_state_next     = r_state;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
            case (r_state)
                RV_EMPTY: begin
                    if (w_i_fire) begin
                        w_state_next   = RV_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                RV_ONE: begin
                    if (w_i_fire && w_o_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_i_fire) begin
                        w_state_next = RV_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_o_fire) begin
                        w_state_next = RV_EMPTY;
                    end
                end
                RV_FULL: begin
                    if (w_o_fire) begin
                        w_state_next     = RV_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_next = RV_EMPTY;
            endcase
        end

        // State and registered ready; ready drops only when skid will hold data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= RV_EMPTY;
                r_ready_q <= 1'b0;
            end else begin
                r_state   <= w_state_next;
                r_ready_q <= (w_state_next != RV_FULL);
            end
        end

        // Payload registers: main feeds the output, skid absorbs one extra beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end else begin
                if (w_load_main_in) begin
                    r_main_data <= i_data;
                end else if (w_load_main_skid) begin
                    r_main_data <= r_skid_data;
                end
                if (w_load_skid) begin
                    r_skid_data <= i_data;
                end
            end
        end

        assign o_valid = (r_state != RV_EMPTY);
        assign o_data  = r_main_data;
        assign i_ready = r_ready_q;
        assign count   = RV_COUNT_W'(r_state);

    end else if (FORWARD_REG) begin : g_fwd
        logic                  r_main_valid;
        logic [DATA_WIDTH-1:0] r_main_data;
        logic                  w_i_fire;
        logic                  w_o_fire;

        assign i_ready  = !r_main_valid || o_ready;
        assign w_i_fire = rv_fire(i_valid, i_ready);
        assign w_o_fire = rv_fire(r_main_valid, o_ready);

        // Single pipeline register: load on accept, clear when drained.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_main_valid <= 1'b0;
                r_main_data  <= '0;
            end else if (w_i_fire) begin
                r_main_valid <= 1'b1;
                r_main_data  <= i_data;
            end else if (w_o_fire) begin
                r_main_valid <= 1'b0;
            end
        end

        assign o_valid = r_main_valid;
        assign o_data  = r_main_data;
        assign count   = RV_COUNT_W'(r_main_valid);

    end else if (BACKWARD_REG) begin : g_bwd
        logic                  r_skid_valid;
        logic                  w_skid_valid_next;
        logic                  r_ready_q;
        logic [DATA_WIDTH-1:0] r_skid_data;
        logic                  w_i_fire;

        assign w_i_fire = rv_fire(i_valid, r_ready_q);

        // Skid fills when an accepted beat cannot pass, empties when it drains.
        always_comb begin
            w_skid_valid_next = r_skid_valid;
            if (r_skid_valid) begin
                if (o_ready) begin
                    w_skid_valid_next = 1'b0;
                end
            end else if (w_i_fire && !o_ready) begin
                w_skid_valid_next = 1'b1;
            end
        end

        // Skid register and the registered ready derived from it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_skid_valid <= 1'b0;
                r_ready_q    <= 1'b0;
                r_skid_data  <= '0;
            end else begin
                r_skid_valid <= w_skid_valid_next;
                r_ready_q    <= !w_skid_valid_next;
                if (!r_skid_valid && w_i_fire && !o_ready) begin
                    r_skid_data <= i_data;
                end
            end
        end

        // Pass-through is gated by ready so nothing leaves before it is accepted.
        assign o_valid = r_skid_valid || (i_valid && r_ready_q);
        assign o_data  = r_skid_valid ? r_skid_data : i_data;
        assign i_ready = r_ready_q;
        assign count   = RV_COUNT_W'(r_skid_valid);

    end else begin : g_wire
        assign o_valid = i_valid;
        assign o_data  = i_data;
        assign i_ready = o_ready;
        assign count   = '0;
    end

endmodule
